// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Pipeline EX stage: operand forwarding, ALU, destination select,
//            EX/MEM register and a 32-step iterative unsigned multiplier.
// Revision : 1.0
// ============================================================================
module ex_stage #(
    parameter int MULT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        regwritee,
    input  logic        memtorege,
    input  logic        memwritee,
    input  logic        alusrce,
    input  logic        jumplinke,
    input  logic [1:0]  regdste,
    input  logic [2:0]  alucontrole,
    input  logic [31:0] rd1e,
    input  logic [31:0] rd2e,
    input  logic [31:0] signimme,
    input  logic [31:0] pcplus4e,
    input  logic [4:0]  rte,
    input  logic [4:0]  rde,
    input  logic [1:0]  forwardae,
    input  logic [1:0]  forwardbe,
    input  logic [31:0] resultw,
    input  logic [31:0] aluoutfwd,
    input  logic        multe,
    output logic        stalle,
    output logic        regwritem,
    output logic        memtoregm,
    output logic        memwritem,
    output logic        jumplinkm,
    output logic [31:0] aluoutm,
    output logic [31:0] writedatam,
    output logic [31:0] pcplus4m,
    output logic [4:0]  writeregm,
    output logic        zerom,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [4:0] C_LAST_STEP = 5'(MULT_CYCLES - 1);

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [4:0]  r_count;

    logic [31:0] w_srca;
    logic [31:0] w_fwdb;
    logic [31:0] w_srcb;
    logic [31:0] w_alu;
    logic [4:0]  w_writereg;
    logic [31:0] w_partial;
    logic [32:0] w_sum;

    always_comb begin
        w_srca = rd1e;
        case (forwardae)
            2'b01:   w_srca = resultw;
            2'b10:   w_srca = aluoutfwd;
            default: w_srca = rd1e;
        endcase
    end

    always_comb begin
        w_fwdb = rd2e;
        case (forwardbe)
            2'b01:   w_fwdb = resultw;
            2'b10:   w_fwdb = aluoutfwd;
            default: w_fwdb = rd2e;
        endcase
    end

    assign w_srcb = alusrce ? signimme : w_fwdb;

    always_comb begin
        w_alu = 32'd0;
        case (alucontrole)
            3'b000:  w_alu = w_srca & w_srcb;
            3'b001:  w_alu = w_srca | w_srcb;
            3'b010:  w_alu = w_srca + w_srcb;
            3'b011:  w_alu = 32'd0;
            3'b100:  w_alu = w_srca & ~w_srcb;
            3'b101:  w_alu = w_srca | ~w_srcb;
            3'b110:  w_alu = w_srca - w_srcb;
            3'b111:  w_alu = ($signed(w_srca) < $signed(w_srcb)) ? 32'd1 : 32'd0;
            default: w_alu = 32'd0;
        endcase
    end

    always_comb begin
        w_writereg = rte;
        case (regdste)
            2'b01:   w_writereg = rde;
            2'b10:   w_writereg = 5'd31;
            default: w_writereg = rte;
        endcase
    end

    // Right-shifting shift-add: the upper half accumulates, the low half
    // collects finished product bits; 32 steps leave the full product.
    assign w_partial = r_mplier[0] ? r_mcand : 32'd0;
    assign w_sum     = {1'b0, r_acc[63:32]} + {1'b0, w_partial};

    assign stalle = rstn & (((r_state == S_IDLE) & multe) | (r_state == S_BUSY));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_count  <= 5'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (multe) begin
                        r_state  <= S_BUSY;
                        r_mcand  <= w_srca;
                        r_mplier <= w_fwdb;
                        r_acc    <= 64'd0;
                        r_count  <= 5'd0;
                    end
                end
                S_BUSY: begin
                    r_acc    <= {w_sum, r_acc[31:1]};
                    r_mplier <= {1'b0, r_mplier[31:1]};
                    r_count  <= r_count + 5'd1;
                    if (r_count == C_LAST_STEP) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    hi      <= r_acc[63:32];
                    lo      <= r_acc[31:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || stalle) begin
            regwritem  <= 1'b0;
            memtoregm  <= 1'b0;
            memwritem  <= 1'b0;
            jumplinkm  <= 1'b0;
            aluoutm    <= 32'd0;
            writedatam <= 32'd0;
            pcplus4m   <= 32'd0;
            writeregm  <= 5'd0;
            zerom      <= 1'b0;
        end else begin
            regwritem  <= regwritee;
            memtoregm  <= memtorege;
            memwritem  <= memwritee;
            jumplinkm  <= jumplinke;
            aluoutm    <= w_alu;
            writedatam <= w_fwdb;
            pcplus4m   <= pcplus4e;
            writeregm  <= w_writereg;
            zerom      <= (w_alu == 32'd0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage: directed table, randomized
//            reference-model vectors, multiply and reset sequences.
// Revision : 1.0
// ============================================================================
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        regwritee, memtorege, memwritee, alusrce, jumplinke;
    logic [1:0]  regdste;
    logic [2:0]  alucontrole;
    logic [31:0] rd1e, rd2e, signimme, pcplus4e;
    logic [4:0]  rte, rde;
    logic [1:0]  forwardae, forwardbe;
    logic [31:0] resultw, aluoutfwd;
    logic        multe;
    logic        stalle;
    logic        regwritem, memtoregm, memwritem, jumplinkm;
    logic [31:0] aluoutm, writedatam, pcplus4m;
    logic [4:0]  writeregm;
    logic        zerom;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_stage #(.MULT_CYCLES(32)) dut (
        .clk(clk), .rstn(rstn),
        .regwritee(regwritee), .memtorege(memtorege), .memwritee(memwritee),
        .alusrce(alusrce), .jumplinke(jumplinke),
        .regdste(regdste), .alucontrole(alucontrole),
        .rd1e(rd1e), .rd2e(rd2e), .signimme(signimme), .pcplus4e(pcplus4e),
        .rte(rte), .rde(rde),
        .forwardae(forwardae), .forwardbe(forwardbe),
        .resultw(resultw), .aluoutfwd(aluoutfwd),
        .multe(multe), .stalle(stalle),
        .regwritem(regwritem), .memtoregm(memtoregm), .memwritem(memwritem),
        .jumplinkm(jumplinkm), .aluoutm(aluoutm), .writedatam(writedatam),
        .pcplus4m(pcplus4m), .writeregm(writeregm), .zerom(zerom),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  fa, fb, rdst;
        logic        src, jl;
        logic [31:0] a, b, imm, res, fwd, pc;
        logic [4:0]  rt, rd;
        logic [31:0] exp_alu, exp_wd;
        logic [4:0]  exp_wr;
        logic        exp_zero;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] res, input logic [31:0] fwd);
        if (sel == 2'b01) return res;
        if (sel == 2'b10) return fwd;
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a + b;
            3'd4: return a & ~b;
            3'd5: return a | ~b;
            3'd6: return a - b;
            3'd7: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exmem_zero();
        return (aluoutm == 0) && (writedatam == 0) && (pcplus4m == 0) && (writeregm == 0) &&
               !regwritem && !memtoregm && !memwritem && !jumplinkm && !zerom;
    endfunction

    task automatic drive_vec(input vec_t v);
        alucontrole = v.op; forwardae = v.fa; forwardbe = v.fb; regdste = v.rdst;
        alusrce = v.src; jumplinke = v.jl; rd1e = v.a; rd2e = v.b; signimme = v.imm;
        resultw = v.res; aluoutfwd = v.fwd; pcplus4e = v.pc; rte = v.rt; rde = v.rd;
    endtask

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        logic [31:0] ea, eb, ealu;
        logic [4:0]  ewr;
        logic        rw, mr, mw;
        vec_t        v;

        //                 op    fa     fb     rdst   src  jl   a             b             imm       res        fwd           pc          rt     rd     alu           wd            wr      z
        tbl[0]  = '{3'b010, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 32'd5,        32'd7,        32'd0,    32'd0,     32'd0,        32'd4,      5'd3,  5'd9,  32'd12,       32'd7,        5'd9,  1'b0};
        tbl[1]  = '{3'b111, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 32'd0,        32'd1,        32'd0,    32'd0,     32'hFFFFFFFF, 32'd8,      5'd4,  5'd1,  32'd1,        32'd1,        5'd4,  1'b0};
        tbl[2]  = '{3'b010, 2'b00, 2'b01, 2'b11, 1'b0, 1'b0, 32'd1,        32'd99,       32'd0,    32'h1234,  32'd0,        32'd12,     5'd6,  5'd7,  32'h1235,     32'h1234,     5'd6,  1'b0};
        tbl[3]  = '{3'b010, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 32'd0,        32'd0,        32'd0,    32'd0,     32'd0,        32'h400008, 5'd2,  5'd3,  32'd0,        32'd0,        5'd31, 1'b1};
        tbl[4]  = '{3'b110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'd0,    32'd0,     32'd0,        32'd16,     5'd2,  5'd5,  32'd0,        32'h80000000, 5'd2,  1'b1};
        tbl[5]  = '{3'b001, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 32'h20,       32'hFF,       32'h10,   32'd0,     32'd0,        32'd20,     5'd1,  5'd12, 32'h30,       32'hFF,       5'd12, 1'b0};
        tbl[6]  = '{3'b100, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 32'hF0F0,     32'h00F0,     32'd0,    32'd0,     32'd7,        32'd24,     5'd8,  5'd0,  32'hF000,     32'h00F0,     5'd8,  1'b0};
        tbl[7]  = '{3'b101, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 32'd0,        32'd3,        32'd0,    32'd0,     32'hFFFF0000, 32'd28,     5'd9,  5'd0,  32'h0000FFFF, 32'hFFFF0000, 5'd9,  1'b0};
        tbl[8]  = '{3'b011, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd5,        32'd5,        32'd0,    32'd0,     32'd0,        32'd32,     5'd10, 5'd0,  32'd0,        32'd5,        5'd10, 1'b1};
        tbl[9]  = '{3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,    32'd0,     32'd0,        32'd36,     5'd0,  5'd17, 32'h0F000F00, 32'h0FF00FF0, 5'd17, 1'b0};
        tbl[10] = '{3'b111, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,    32'd0,     32'd0,        32'd40,     5'd11, 5'd0,  32'd0,        32'hFFFFFFFF, 5'd11, 1'b1};

        // Reset with a pending multiply on the inputs
        rstn = 1'b0; multe = 1'b1;
        regwritee = 1'b1; memtorege = 1'b1; memwritee = 1'b1;
        drive_vec(tbl[3]);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_stall", stalle, 0);
        check("reset_exmem", exmem_zero(), 1);
        check("reset_hilo", {hi, lo}, 0);
        multe = 1'b0; rstn = 1'b1; #1;
        check("post_reset_stall", stalle, 0);

        // Directed table
        regwritee = 1'b1; memtorege = 1'b0; memwritee = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_vec(tbl[i]);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_alu", i), aluoutm, tbl[i].exp_alu);
            check($sformatf("tbl%0d_zero", i), zerom, tbl[i].exp_zero);
            check($sformatf("tbl%0d_wd", i), writedatam, tbl[i].exp_wd);
            check($sformatf("tbl%0d_wr", i), writeregm, tbl[i].exp_wr);
            check($sformatf("tbl%0d_ctl", i), {regwritem, jumplinkm, pcplus4m},
                  {1'b1, tbl[i].jl, tbl[i].pc});
        end

        // Multiply 0xFFFFFFFF * 2, operands scrambled while busy
        @(negedge clk);
        rd1e = 32'hFFFFFFFF; rd2e = 32'd2; forwardae = 2'b00; forwardbe = 2'b00;
        alusrce = 1'b0; alucontrole = 3'b010; regdste = 2'b01; rde = 5'd4;
        pcplus4e = 32'h44; multe = 1'b1;
        stall_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stalle) break;
            stall_cnt++;
            @(posedge clk); #1;
            check("mul_bubble", exmem_zero(), 1);
            if (c == 5) begin
                rd1e = $urandom; rd2e = $urandom;
            end
            @(negedge clk);
        end
        check("mul_stall_cycles", stall_cnt, 33);
        ea = rd1e; eb = rd2e;
        @(posedge clk); #1;
        check("mul_hi", hi, 32'h00000001);
        check("mul_lo", lo, 32'hFFFFFFFE);
        check("mul_advance_alu", aluoutm, ea + eb);
        check("mul_advance_wr", writeregm, 5'd4);
        @(negedge clk); multe = 1'b0; #1;
        check("mul_idle_stall", stalle, 0);

        // Randomized vectors against the reference model
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            v.op = 3'($urandom); v.fa = 2'($urandom); v.fb = 2'($urandom);
            v.rdst = 2'($urandom); v.src = 1'($urandom); v.jl = 1'($urandom);
            v.a = $urandom; v.b = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
            v.imm = $urandom; v.res = $urandom; v.fwd = $urandom; v.pc = $urandom;
            v.rt = 5'($urandom); v.rd = 5'($urandom);
            drive_vec(v);
            rw = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
            regwritee = rw; memtorege = mr; memwritee = mw;
            ea = pick(v.fa, v.a, v.res, v.fwd);
            eb = pick(v.fb, v.b, v.res, v.fwd);
            ealu = ref_alu(v.op, ea, v.src ? v.imm : eb);
            ewr = (v.rdst == 2'b01) ? v.rd : (v.rdst == 2'b10) ? 5'd31 : v.rt;
            #1;
            check("rnd_stall", stalle, 0);
            @(posedge clk); #1;
            check("rnd_alu", aluoutm, ealu);
            check("rnd_zero", zerom, ealu == 0);
            check("rnd_wd", writedatam, eb);
            check("rnd_wr", writeregm, ewr);
            check("rnd_ctl", {regwritem, memtoregm, memwritem, jumplinkm, pcplus4m},
                  {rw, mr, mw, v.jl, v.pc});
            check("rnd_hilo_hold", {hi, lo}, 64'h00000001_FFFFFFFE);
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        rd1e = $urandom; rd2e = $urandom; forwardae = 2'b00; forwardbe = 2'b00;
        regwritee = 1'b1; multe = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("midmul_busy", stalle, 1);
        rstn = 1'b0; #1;
        check("midmul_rst_stall", stalle, 0);
        @(posedge clk); #1;
        check("midmul_rst_hilo", {hi, lo}, 0);
        check("midmul_rst_exmem", exmem_zero(), 1);
        @(negedge clk);
        rstn = 1'b1; multe = 1'b0; #1;
        check("midmul_idle_nomul", stalle, 0);
        multe = 1'b1; #1;
        check("midmul_idle_mul", stalle, 1);
        multe = 1'b0;
        @(posedge clk); #1;
        check("midmul_hilo_hold", {hi, lo}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
